dmem_responder: RTL and testbench

- Data-memory responder at the far end of the core's load/store request path.
- Accepts one request at a time from the execute/memory stage: address, write flag, store data and access size, the same encoding the decoder drives on load_size_out.
- Holds a word-organised RAM, inserts a programmable number of wait states, applies byte-lane write strobes, and returns read data or an error through a valid/ready response handshake.
- Misaligned and out-of-range accesses are rejected without side effects.

---
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 tb/tb_dmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: takes one load/store request at a time, waits a
// programmable number of cycles, then accesses a word-organised RAM with
// byte-lane strobes and returns the full word or an error via valid/ready.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic [31:0] addr_in,
  input  logic        wr_req_in,
  input  logic [31:0] wr_data_in,
  input  logic [1:0]  load_size_in,
  output logic        rsp_valid_out,
  input  logic        rsp_ready_in,
  output logic [31:0] rd_data_out,
  output logic        rsp_err_out,
  output logic        busy_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                  state_q;
  logic [3:0]              waitCnt_q;
  logic [ADDR_WIDTH-1:0]   wordIdx_q;
  logic [1:0]              lane_q;
  logic                    wr_q;
  logic [31:0]             wrData_q;
  logic [1:0]              size_q;
  logic                    err_q;
  logic [31:0]             rdData_q;
  logic                    rspErr_q;
  logic                    rspValid_q;
  logic                    reqReady_q;
  logic                    busy_q;

  logic                    reqErr;
  logic [3:0]              strb;
  logic [31:0]             laneData;

  logic [31:0]             mem [0:DEPTH-1];

  // Classify the incoming request: misaligned, illegal size or beyond the RAM.
  always_comb begin
    reqErr = 1'b0;
    case (load_size_in)
      2'b01:   reqErr = addr_in[0];
      2'b10:   reqErr = |addr_in[1:0];
      2'b11:   reqErr = 1'b1;
      default: reqErr = 1'b0;
    endcase
    if ((addr_in >> (ADDR_WIDTH + 2)) != 32'd0) begin
      reqErr = 1'b1;
    end
  end

  // Byte-lane strobes and lane-replicated store data for the captured request.
  always_comb begin
    strb     = 4'b0000;
    laneData = wrData_q;
    case (size_q)
      2'b00: begin
        strb     = 4'b0001 << lane_q;
        laneData = {4{wrData_q[7:0]}};
      end
      2'b01: begin
        strb     = lane_q[1] ? 4'b1100 : 4'b0011;
        laneData = {2{wrData_q[15:0]}};
      end
      2'b10: begin
        strb     = 4'b1111;
        laneData = wrData_q;
      end
      default: begin
        strb     = 4'b0000;
        laneData = wrData_q;
      end
    endcase
  end

  // Request/response FSM with registered handshake and status outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      waitCnt_q  <= 4'd0;
      wordIdx_q  <= '0;
      lane_q     <= 2'b00;
      wr_q       <= 1'b0;
      wrData_q   <= 32'd0;
      size_q     <= 2'b00;
      err_q      <= 1'b0;
      rdData_q   <= 32'd0;
      rspErr_q   <= 1'b0;
      rspValid_q <= 1'b0;
      reqReady_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_in && reqReady_q) begin
            wordIdx_q  <= addr_in[ADDR_WIDTH+1:2];
            lane_q     <= addr_in[1:0];
            wr_q       <= wr_req_in;
            wrData_q   <= wr_data_in;
            size_q     <= load_size_in;
            err_q      <= reqErr;
            reqReady_q <= 1'b0;
            busy_q     <= 1'b1;
            if (WAIT_STATES > 0) begin
              state_q   <= S_WAIT;
              waitCnt_q <= WAIT_INIT;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (waitCnt_q == 4'd0) begin
            state_q <= S_ACCESS;
          end else begin
            waitCnt_q <= waitCnt_q - 4'd1;
          end
        end
        S_ACCESS: begin
          state_q    <= S_RESP;
          rspValid_q <= 1'b1;
          rspErr_q   <= err_q;
          rdData_q   <= (!err_q && !wr_q) ? mem[wordIdx_q] : 32'd0;
        end
        S_RESP: begin
          if (rsp_ready_in) begin
            state_q    <= S_IDLE;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rdData_q   <= 32'd0;
            reqReady_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // RAM write port; only a clean store that reaches ACCESS touches memory.
  always_ff @(posedge clk_in) begin
    if (state_q == S_ACCESS && wr_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) begin
          mem[wordIdx_q][8*i +: 8] <= laneData[8*i +: 8];
        end
      end
    end
  end

  assign req_ready_out = reqReady_q;
  assign rsp_valid_out = rspValid_q;
  assign rd_data_out   = rdData_q;
  assign rsp_err_out   = rspErr_q;
  assign busy_out      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic checked
// against a byte-addressed memory model.
module tb_dmem_responder;

  localparam int AW     = 10;
  localparam int WS     = 2;
  localparam int NBYTES = 4 << AW;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic [31:0] addr_in = 32'd0;
  logic        wr_req_in = 1'b0;
  logic [31:0] wr_data_in = 32'd0;
  logic [1:0]  load_size_in = 2'b00;
  logic        rsp_valid_out;
  logic        rsp_ready_in = 1'b0;
  logic [31:0] rd_data_out;
  logic        rsp_err_out;
  logic        busy_out;

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0] m8 [0:NBYTES-1];

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .addr_in       (addr_in),
    .wr_req_in     (wr_req_in),
    .wr_data_in    (wr_data_in),
    .load_size_in  (load_size_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_ready_in  (rsp_ready_in),
    .rd_data_out   (rd_data_out),
    .rsp_err_out   (rsp_err_out),
    .busy_out      (busy_out)
  );

  // Free-running clock.
  always #5 clk_in = ~clk_in;

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // A request is rejected when its size is illegal, it is misaligned, or it lies beyond the RAM.
  function automatic bit modelErr(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) || (a >= NBYTES);
  endfunction

  // Run one full request/response transaction and check it against the model.
  task automatic applyStimulus(input logic [31:0] a, input bit w, input logic [31:0] d,
                               input logic [1:0] s, input int hold,
                               output logic [31:0] obsData, output logic obsErr);
    logic [31:0] expData;
    logic [31:0] base;
    bit          expErr;
    int          k;
    expErr  = modelErr(a, s);
    expData = 32'd0;
    obsData = 32'd0;
    obsErr  = 1'b0;
    if (!expErr) begin
      if (w) begin
        for (int i = 0; i < (1 << s); i++) m8[a + i] = d[8*i +: 8];
      end else begin
        base    = a & ~32'h3;
        expData = {m8[base + 3], m8[base + 2], m8[base + 1], m8[base]};
      end
    end
    @(negedge clk_in);
    checkOutput("req_ready idle", {31'd0, req_ready_out}, 32'd1);
    addr_in      = a;
    wr_req_in    = w;
    wr_data_in   = d;
    load_size_in = s;
    req_valid_in = 1'b1;
    k = 0;
    do begin
      @(negedge clk_in);
      k++;
      req_valid_in = 1'b0;
    end while (!rsp_valid_out && k < 40);
    if (!rsp_valid_out) begin
      checkOutput("rsp timeout", {31'd0, rsp_valid_out}, 32'd1);
      return;
    end
    checkOutput("latency", k, WS + 2);
    checkOutput("rsp_err", {31'd0, rsp_err_out}, {31'd0, expErr});
    checkOutput("rd_data", rd_data_out, expData);
    checkOutput("busy in resp", {31'd0, busy_out}, 32'd1);
    obsData = rd_data_out;
    obsErr  = rsp_err_out;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_in);
      checkOutput("hold valid", {31'd0, rsp_valid_out}, 32'd1);
      checkOutput("hold data", rd_data_out, expData);
      checkOutput("hold err", {31'd0, rsp_err_out}, {31'd0, expErr});
      checkOutput("hold req_ready", {31'd0, req_ready_out}, 32'd0);
    end
    rsp_ready_in = 1'b1;
    @(negedge clk_in);
    rsp_ready_in = 1'b0;
    checkOutput("post valid", {31'd0, rsp_valid_out}, 32'd0);
    checkOutput("post data", rd_data_out, 32'd0);
    checkOutput("post err", {31'd0, rsp_err_out}, 32'd0);
    checkOutput("post req_ready", {31'd0, req_ready_out}, 32'd1);
    checkOutput("post busy", {31'd0, busy_out}, 32'd0);
  endtask

  // Reset, preload, directed scenarios, random traffic, then reset-during-wait.
  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] a;
    logic [1:0]  s;
    bit          w;
    int          r;

    repeat (3) @(negedge clk_in);
    checkOutput("reset req_ready", {31'd0, req_ready_out}, 32'd1);
    checkOutput("reset valid", {31'd0, rsp_valid_out}, 32'd0);
    checkOutput("reset data", rd_data_out, 32'd0);
    checkOutput("reset err", {31'd0, rsp_err_out}, 32'd0);
    checkOutput("reset busy", {31'd0, busy_out}, 32'd0);
    rst_in = 1'b1;
    @(negedge clk_in);
    checkOutput("release req_ready", {31'd0, req_ready_out}, 32'd1);
    checkOutput("release busy", {31'd0, busy_out}, 32'd0);

    // Spec scenario first, straight out of reset.
    applyStimulus(32'h10, 1'b1, 32'hDEADBEEF, 2'b10, 0, d, e);
    checkOutput("word store err", {31'd0, e}, 32'd0);

    for (int i = 0; i < 32; i++) begin
      if (i != 4) applyStimulus(32'(i * 4), 1'b1, $urandom, 2'b10, 0, d, e);
    end

    applyStimulus(32'h10, 1'b0, 32'd0, 2'b10, 0, d, e);
    checkOutput("load DEADBEEF", d, 32'hDEADBEEF);
    applyStimulus(32'h13, 1'b1, 32'h000000AA, 2'b00, 0, d, e);
    applyStimulus(32'h10, 1'b0, 32'd0, 2'b10, 0, d, e);
    checkOutput("load after byte", d, 32'hAAADBEEF);
    applyStimulus(32'h12, 1'b1, 32'h00001234, 2'b01, 0, d, e);
    applyStimulus(32'h10, 1'b0, 32'd0, 2'b10, 0, d, e);
    checkOutput("load after half", d, 32'h1234BEEF);
    applyStimulus(32'h11, 1'b1, 32'h00005678, 2'b01, 0, d, e);
    checkOutput("misaligned half err", {31'd0, e}, 32'd1);
    checkOutput("misaligned half data", d, 32'd0);
    applyStimulus(32'h10, 1'b0, 32'd0, 2'b10, 0, d, e);
    checkOutput("ram unchanged", d, 32'h1234BEEF);
    applyStimulus(32'h16, 1'b0, 32'd0, 2'b10, 0, d, e);
    checkOutput("misaligned word err", {31'd0, e}, 32'd1);
    applyStimulus(32'h00001000, 1'b0, 32'd0, 2'b10, 0, d, e);
    checkOutput("out of range err", {31'd0, e}, 32'd1);
    applyStimulus(32'h10, 1'b0, 32'd0, 2'b11, 0, d, e);
    checkOutput("illegal size err", {31'd0, e}, 32'd1);
    applyStimulus(32'h10, 1'b0, 32'd0, 2'b10, 5, d, e);
    checkOutput("backpressure data", d, 32'h1234BEEF);

    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 7);
      a = (r == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 127));
      s = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      applyStimulus(a, w, $urandom, s, $urandom_range(0, 2), d, e);
    end

    // Store to 0x20 abandoned by reset while waiting.
    @(negedge clk_in);
    addr_in      = 32'h20;
    wr_req_in    = 1'b1;
    wr_data_in   = ~{m8[35], m8[34], m8[33], m8[32]};
    load_size_in = 2'b10;
    req_valid_in = 1'b1;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    checkOutput("wait busy", {31'd0, busy_out}, 32'd1);
    checkOutput("wait req_ready", {31'd0, req_ready_out}, 32'd0);
    rst_in = 1'b0;
    #1;
    checkOutput("async req_ready", {31'd0, req_ready_out}, 32'd1);
    checkOutput("async busy", {31'd0, busy_out}, 32'd0);
    checkOutput("async valid", {31'd0, rsp_valid_out}, 32'd0);
    checkOutput("async data", rd_data_out, 32'd0);
    checkOutput("async err", {31'd0, rsp_err_out}, 32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    applyStimulus(32'h20, 1'b0, 32'd0, 2'b10, 0, d, e);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
